// File: rtl/udt_pkg.sv
// Shared UDT connection-state encodings and widths.
// Used by configure to decode udt_state reports.
`timescale 1ns/1ps
package udt_pkg;

    typedef enum logic [3:0] {
        UDT_CLOSED     = 4'd0,
        UDT_CONNECTING = 4'd1,
        UDT_CONNECTED  = 4'd2,
        UDT_CLOSING    = 4'd3,
        UDT_BROKEN     = 4'd4
    } udt_state_t;

    localparam int RETRY_W = 8;

endpackage

// File: rtl/udt_timer.sv
// Loadable down-counter: load sets HS_TIMEOUT-1, expired is high on the cycle it reaches 0.
// Latency: expiry HS_TIMEOUT cycles after load; load wins over a same-cycle expiry, clear stops it.
`timescale 1ns/1ps
module udt_timer #(
    parameter int HS_TIMEOUT = 1000,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic expired
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HS_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;
    logic             running;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (load) begin
            cnt     <= LOAD_VAL;
            running <= 1'b1;
        end else if (running) begin
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Only a timer that was loaded can expire; an idle zero count is not an event.
    assign expired = running && (cnt == '0);

endmodule

// File: rtl/udt_conn_ctrl.sv
// UDT connection FSM: handshake retries, local/peer close, state reporting to configure.
// All outputs registered, one cycle after the causing input; state reports coalesce until accepted.
`timescale 1ns/1ps
module udt_conn_ctrl
    import udt_pkg::*;
#(
    parameter int HS_TIMEOUT = 1000,
    parameter int HS_RETRY   = 8,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_connect,
    output logic       res_connect,
    input  logic       req_close,
    output logic       res_close,
    input  logic       peer_req_close,
    output logic       peer_res_close,
    output logic       hs_send,
    input  logic       hs_ack,
    output logic       shutdown_send,
    output logic [3:0] udt_state,
    output logic       state_valid,
    input  logic       state_ready
);

    udt_state_t         state;
    udt_state_t         nxt;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_n;
    logic               connect_hist;
    logic               armed;
    logic               connect_edge;
    logic               tmr_load;
    logic               tmr_clear;
    logic               tmr_expired;
    logic               hs_send_n;
    logic               res_connect_n;
    logic               res_close_n;
    logic               peer_res_close_n;
    logic               shutdown_send_n;

    // A level held high across reset must not look like a fresh request, so the
    // edge detector is gated until the history register has sampled once.
    assign connect_edge = armed && req_connect && !connect_hist;

    udt_timer #(
        .HS_TIMEOUT (HS_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .clear   (tmr_clear),
        .expired (tmr_expired)
    );

    always_comb begin
        nxt              = state;
        retry_n          = retry;
        tmr_load         = 1'b0;
        tmr_clear        = 1'b0;
        hs_send_n        = 1'b0;
        res_connect_n    = 1'b0;
        res_close_n      = 1'b0;
        peer_res_close_n = 1'b0;
        shutdown_send_n  = 1'b0;
        case (state)
            UDT_CLOSED: begin
                if (connect_edge) begin
                    hs_send_n = 1'b1;
                    tmr_load  = 1'b1;
                    retry_n   = RETRY_W'(1);
                    nxt       = UDT_CONNECTING;
                end
            end
            UDT_CONNECTING: begin
                if (req_close) begin
                    res_close_n = 1'b1;
                    tmr_clear   = 1'b1;
                    nxt         = UDT_CLOSED;
                end else if (hs_ack) begin
                    res_connect_n = 1'b1;
                    tmr_clear     = 1'b1;
                    nxt           = UDT_CONNECTED;
                end else if (tmr_expired) begin
                    if (retry < RETRY_W'(HS_RETRY)) begin
                        hs_send_n = 1'b1;
                        tmr_load  = 1'b1;
                        retry_n   = retry + RETRY_W'(1);
                    end else begin
                        nxt = UDT_BROKEN;
                    end
                end
            end
            UDT_CONNECTED: begin
                // Peer shutdown wins; a same-cycle local close is completed without a shutdown packet.
                if (peer_req_close) begin
                    peer_res_close_n = 1'b1;
                    res_close_n      = req_close;
                    nxt              = UDT_CLOSED;
                end else if (req_close) begin
                    shutdown_send_n = 1'b1;
                    tmr_load        = 1'b1;
                    nxt             = UDT_CLOSING;
                end
            end
            UDT_CLOSING: begin
                if (peer_req_close) begin
                    res_close_n      = 1'b1;
                    peer_res_close_n = 1'b1;
                    tmr_clear        = 1'b1;
                    nxt              = UDT_CLOSED;
                end else if (tmr_expired) begin
                    res_close_n = 1'b1;
                    nxt         = UDT_CLOSED;
                end
            end
            UDT_BROKEN: begin
                if (req_close) begin
                    res_close_n = 1'b1;
                    nxt         = UDT_CLOSED;
                end
            end
            default: begin
                tmr_clear = 1'b1;
                nxt       = UDT_CLOSED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= UDT_CLOSED;
            retry          <= '0;
            connect_hist   <= 1'b0;
            armed          <= 1'b0;
            state_valid    <= 1'b0;
            hs_send        <= 1'b0;
            res_connect    <= 1'b0;
            res_close      <= 1'b0;
            peer_res_close <= 1'b0;
            shutdown_send  <= 1'b0;
        end else begin
            state          <= nxt;
            retry          <= retry_n;
            connect_hist   <= req_connect;
            armed          <= 1'b1;
            hs_send        <= hs_send_n;
            res_connect    <= res_connect_n;
            res_close      <= res_close_n;
            peer_res_close <= peer_res_close_n;
            shutdown_send  <= shutdown_send_n;
            // A new change keeps (or re-raises) the report even in the accept cycle.
            if (nxt != state) begin
                state_valid <= 1'b1;
            end else if (state_valid && state_ready) begin
                state_valid <= 1'b0;
            end
        end
    end

    assign udt_state = state;

endmodule

// File: tb/tb_udt_conn_ctrl.sv
// Directed bench for udt_conn_ctrl with HS_TIMEOUT=10, HS_RETRY=3.
`timescale 1ns/1ps
module tb_udt_conn_ctrl;

    logic       clk;
    logic       rst;
    logic       req_connect;
    logic       res_connect;
    logic       req_close;
    logic       res_close;
    logic       peer_req_close;
    logic       peer_res_close;
    logic       hs_send;
    logic       hs_ack;
    logic       shutdown_send;
    logic [3:0] udt_state;
    logic       state_valid;
    logic       state_ready;

    int n_cmp;
    int n_err;
    int cnt;

    udt_conn_ctrl #(
        .HS_TIMEOUT (10),
        .HS_RETRY   (3),
        .CNT_W      (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_connect    (req_connect),
        .res_connect    (res_connect),
        .req_close      (req_close),
        .res_close      (res_close),
        .peer_req_close (peer_req_close),
        .peer_res_close (peer_res_close),
        .hs_send        (hs_send),
        .hs_ack         (hs_ack),
        .shutdown_send  (shutdown_send),
        .udt_state      (udt_state),
        .state_valid    (state_valid),
        .state_ready    (state_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_connect();
        req_connect = 1'b1;
        tick();
        hs_ack = 1'b1;
        tick();
        hs_ack      = 1'b0;
        req_connect = 1'b0;
        chk("conn_state", int'(udt_state), 2);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst            = 1'b1;
        req_connect    = 1'b0;
        req_close      = 1'b0;
        peer_req_close = 1'b0;
        hs_ack         = 1'b0;
        state_ready    = 1'b1;
        tick();
        tick();
        chk("rst_state", int'(udt_state), 0);
        chk("rst_valid", int'(state_valid), 0);
        chk("rst_pulses", int'({hs_send, res_connect, res_close, peer_res_close, shutdown_send}), 0);
        rst = 1'b0;
        tick();

        // Connect, ack 5 cycles later
        req_connect = 1'b1;
        tick();
        chk("t1_hs_send", int'(hs_send), 1);
        chk("t1_state", int'(udt_state), 1);
        chk("t1_valid", int'(state_valid), 1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            cnt += int'(hs_send);
            if (i == 0) chk("t1_valid_clr", int'(state_valid), 0);
        end
        chk("t1_hs_once", cnt, 0);
        hs_ack = 1'b1;
        tick();
        hs_ack = 1'b0;
        chk("t1_connected", int'(udt_state), 2);
        chk("t1_res_connect", int'(res_connect), 1);
        chk("t1_valid2", int'(state_valid), 1);
        tick();
        chk("t1_res_connect_end", int'(res_connect), 0);
        req_connect = 1'b0;

        // Local close with linger
        req_close = 1'b1;
        tick();
        req_close = 1'b0;
        chk("t2_shutdown", int'(shutdown_send), 1);
        chk("t2_closing", int'(udt_state), 3);
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            cnt += int'(shutdown_send) + int'(res_close);
        end
        chk("t2_linger_state", int'(udt_state), 3);
        chk("t2_linger_pulses", cnt, 0);
        tick();
        chk("t2_closed", int'(udt_state), 0);
        chk("t2_res_close", int'(res_close), 1);
        tick();
        chk("t2_res_close_end", int'(res_close), 0);

        // Handshake retries exhausted
        req_connect = 1'b1;
        tick();
        chk("t3_hs_t0", int'(hs_send), 1);
        cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (hs_send) begin
                cnt++;
                chk("t3_hs_time", int'(k == 10 || k == 20), 1);
            end
            if (k == 29) chk("t3_state_29", int'(udt_state), 1);
        end
        chk("t3_broken", int'(udt_state), 4);
        chk("t3_hs_count", cnt, 2);
        for (int i = 0; i < 15; i++) begin
            tick();
            cnt += int'(hs_send);
        end
        chk("t3_no_fourth", cnt, 2);
        req_connect    = 1'b0;
        peer_req_close = 1'b1;
        tick();
        peer_req_close = 1'b0;
        chk("t3_peer_ignored", int'(peer_res_close), 0);
        req_connect = 1'b1;
        tick();
        tick();
        chk("t3_broken_hold", int'(udt_state), 4);
        chk("t3_broken_no_hs", int'(hs_send), 0);
        req_close = 1'b1;
        tick();
        req_close = 1'b0;
        chk("t3_broken_close", int'(udt_state), 0);
        chk("t3_broken_res", int'(res_close), 1);
        req_connect = 1'b0;
        tick();

        // Simultaneous local and peer close in CONNECTED
        do_connect();
        req_close      = 1'b1;
        peer_req_close = 1'b1;
        tick();
        req_close      = 1'b0;
        peer_req_close = 1'b0;
        chk("t4_state", int'(udt_state), 0);
        chk("t4_pulses", int'({peer_res_close, res_close, shutdown_send}), 6);

        // req_close beats hs_ack in CONNECTING
        req_connect = 1'b1;
        tick();
        req_close = 1'b1;
        hs_ack    = 1'b1;
        tick();
        req_close = 1'b0;
        hs_ack    = 1'b0;
        chk("t5_state", int'(udt_state), 0);
        chk("t5_pulses", int'({res_close, res_connect}), 2);
        req_connect = 1'b0;
        tick();

        // hs_ack beats same-cycle expiry
        req_connect = 1'b1;
        tick();
        repeat (9) tick();
        hs_ack = 1'b1;
        tick();
        hs_ack      = 1'b0;
        req_connect = 1'b0;
        chk("t6_state", int'(udt_state), 2);
        chk("t6_pulses", int'({hs_send, res_connect}), 1);

        // Peer close alone in CONNECTED
        peer_req_close = 1'b1;
        tick();
        peer_req_close = 1'b0;
        chk("t7_state", int'(udt_state), 0);
        chk("t7_pulses", int'({peer_res_close, res_close}), 2);

        // Peer close during CLOSING
        do_connect();
        req_close = 1'b1;
        tick();
        req_close = 1'b0;
        tick();
        tick();
        peer_req_close = 1'b1;
        tick();
        peer_req_close = 1'b0;
        chk("t8_state", int'(udt_state), 0);
        chk("t8_pulses", int'({res_close, peer_res_close}), 3);

        // Coalesced reports with state_ready low
        state_ready = 1'b0;
        tick();
        do_connect();
        repeat (3) tick();
        chk("t9_valid_held", int'(state_valid), 1);
        chk("t9_state", int'(udt_state), 2);
        state_ready = 1'b1;
        tick();
        chk("t9_valid_clr", int'(state_valid), 0);
        peer_req_close = 1'b1;
        tick();
        peer_req_close = 1'b0;
        tick();

        // Asynchronous reset mid-handshake
        req_connect = 1'b1;
        tick();
        chk("t10_hs_pre", int'(hs_send), 1);
        rst = 1'b1;
        #1;
        chk("t10_async_state", int'(udt_state), 0);
        chk("t10_async_valid", int'(state_valid), 0);
        chk("t10_async_hs", int'(hs_send), 0);
        tick();
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += int'(hs_send) + int'(res_close) + int'(res_connect) + int'(state_valid);
        end
        chk("t10_no_reconnect", cnt, 0);
        chk("t10_state_closed", int'(udt_state), 0);
        req_connect = 1'b0;
        tick();
        req_connect = 1'b1;
        tick();
        chk("t10_reedge_hs", int'(hs_send), 1);
        chk("t10_reedge_state", int'(udt_state), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
